// File: rtl/modexp_pkg.sv
// ---------------------------------------------------------------------------
// modexp_pkg: shared FSM state type and width helpers for modexp_engine. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package modexp_pkg;

  localparam int MSG_WIDTH_DEF = 16;
  localparam int KEY_WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHECK     = 3'd1,
    REDUCE_IN = 3'd2,
    MUL       = 3'd3,
    SQR       = 3'd4,
    DONE      = 3'd5
  } modexp_state_t;

  function automatic int prod_w(input int kw);
    return 2 * kw;
  endfunction

  function automatic int idx_w(input int kw);
    return (kw > 1) ? $clog2(kw) : 1;
  endfunction

  localparam int PROD_WIDTH_DEF = prod_w(KEY_WIDTH_DEF);
  localparam int IDX_WIDTH_DEF  = idx_w(KEY_WIDTH_DEF);

endpackage

`default_nettype wire

// File: rtl/modexp_if.sv
// ---------------------------------------------------------------------------
// modexp_if: start/operand/result bundle between key store and modexp_engine. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface modexp_if #(
  parameter int MSG_WIDTH = 16,
  parameter int KEY_WIDTH = 16
);
  logic                 ready_in;
  logic [MSG_WIDTH-1:0] value_in;
  logic [KEY_WIDTH-1:0] modulus_in;
  logic [KEY_WIDTH-1:0] exponent_in;
  logic [KEY_WIDTH-1:0] value_out;
  logic                 busy_out;
  logic                 valid_out;
  logic                 error_out;

  modport master (
    output ready_in, value_in, modulus_in, exponent_in,
    input  value_out, busy_out, valid_out, error_out
  );

  modport slave (
    input  ready_in, value_in, modulus_in, exponent_in,
    output value_out, busy_out, valid_out, error_out
  );
endinterface

`default_nettype wire

// File: rtl/mod_mult_step.sv
// ---------------------------------------------------------------------------
// mod_mult_step: (a*b) mod m, or raw mod m in bypass, by bit-serial restoring reduction. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mod_mult_step
  import modexp_pkg::*;
#(
  parameter int KEY_WIDTH = KEY_WIDTH_DEF
) (
  input  wire logic                           clk,
  input  wire logic                           rst,
  input  wire logic                           start,
  input  wire logic                           bypass,
  input  wire logic [KEY_WIDTH-1:0]           a,
  input  wire logic [KEY_WIDTH-1:0]           b,
  input  wire logic [KEY_WIDTH-1:0]           m,
  input  wire logic [prod_w(KEY_WIDTH)-1:0]   raw,
  output logic                                busy,
  output logic                                valid,
  output logic [KEY_WIDTH-1:0]                result
);

  localparam int PW = prod_w(KEY_WIDTH);
  localparam int CW = $clog2(PW);

  logic [PW-1:0]        r_prod;
  logic [KEY_WIDTH-1:0] r_rem;
  logic [KEY_WIDTH-1:0] r_m;
  logic [CW-1:0]        r_cnt;
  logic [KEY_WIDTH:0]   w_shift;
  logic [KEY_WIDTH:0]   w_diff;
  logic [KEY_WIDTH-1:0] w_next;

  // Remainder stays below m, so one conditional subtract per shifted-in bit suffices.
  always_comb begin
    w_shift = {r_rem, r_prod[PW-1]};
    w_diff  = w_shift - {1'b0, r_m};
    w_next  = (w_shift >= {1'b0, r_m}) ? w_diff[KEY_WIDTH-1:0] : w_shift[KEY_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prod <= '0;
      r_rem  <= '0;
      r_m    <= '0;
      r_cnt  <= '0;
      busy   <= 1'b0;
      valid  <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (!busy) begin
        if (start) begin
          r_prod <= bypass ? raw : (PW'(a) * PW'(b));
          r_rem  <= '0;
          r_m    <= m;
          r_cnt  <= '0;
          busy   <= 1'b1;
        end
      end else begin
        r_prod <= r_prod << 1;
        r_rem  <= w_next;
        r_cnt  <= r_cnt + 1'b1;
        if (r_cnt == CW'(PW - 1)) begin
          busy  <= 1'b0;
          valid <= 1'b1;
        end
      end
    end
  end

  assign result = r_rem;

endmodule

`default_nettype wire

// File: rtl/modexp_engine.sv
// ---------------------------------------------------------------------------
// modexp_engine: value^e mod m, right-to-left square-and-multiply; MODEXP_CONST_TIME_EN selects fixed latency. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module modexp_engine
  import modexp_pkg::*;
#(
  parameter int MSG_WIDTH = MSG_WIDTH_DEF,
  parameter int KEY_WIDTH = KEY_WIDTH_DEF
) (
  input  wire logic clk_in,
  input  wire logic rst_in,
  modexp_if.slave   bus
);

  localparam int PW = prod_w(KEY_WIDTH);
  localparam int IW = idx_w(KEY_WIDTH);

  modexp_state_t        r_state, w_state_next;
  logic [PW-1:0]        r_val;
  logic [KEY_WIDTH-1:0] r_mod, r_exp, r_base, r_acc, r_res;
  logic [IW-1:0]        r_idx;
  logic                 r_err, r_issued;

  logic                 w_step_go, w_step_busy, w_step_valid;
  logic [KEY_WIDTH-1:0] w_step_a, w_step_result;
  logic [KEY_WIDTH-1:0] w_bits;

  assign w_bits = r_exp >> r_idx;

  mod_mult_step #(.KEY_WIDTH(KEY_WIDTH)) u_step (
    .clk    (clk_in),
    .rst    (rst_in),
    .start  (w_step_go),
    .bypass (r_state == REDUCE_IN),
    .a      (w_step_a),
    .b      (r_base),
    .m      (r_mod),
    .raw    (r_val),
    .busy   (w_step_busy),
    .valid  (w_step_valid),
    .result (w_step_result)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_step_go    = 1'b0;
    w_step_a     = (r_state == MUL) ? r_acc : r_base;
    case (r_state)
      IDLE: if (bus.ready_in) w_state_next = CHECK;
      CHECK: begin
        if (r_mod == '0) begin
          w_state_next = DONE;
        end else begin
`ifdef MODEXP_CONST_TIME_EN
          w_state_next = REDUCE_IN;
`else
          w_state_next = ((r_mod == KEY_WIDTH'(1)) || (r_exp == '0)) ? DONE : REDUCE_IN;
`endif
        end
      end
      REDUCE_IN, MUL, SQR: begin
        if (!r_issued) begin
          w_step_go = 1'b1;
        end else if (w_step_valid) begin
`ifdef MODEXP_CONST_TIME_EN
          case (r_state)
            REDUCE_IN: w_state_next = MUL;
            MUL:       w_state_next = SQR;
            default:   w_state_next = (r_idx == IW'(KEY_WIDTH - 1)) ? DONE : MUL;
          endcase
`else
          // w_bits[0] is the current exponent bit, w_bits[1] the next one.
          case (r_state)
            REDUCE_IN: w_state_next = w_bits[0] ? MUL : SQR;
            MUL:       w_state_next = (|w_bits[KEY_WIDTH-1:1]) ? SQR : DONE;
            default:   w_state_next = w_bits[1] ? MUL : SQR;
          endcase
`endif
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_val    <= '0;
      r_mod    <= '0;
      r_exp    <= '0;
      r_base   <= '0;
      r_acc    <= '0;
      r_res    <= '0;
      r_idx    <= '0;
      r_err    <= 1'b0;
      r_issued <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.ready_in) begin
            r_val    <= PW'(bus.value_in);
            r_mod    <= bus.modulus_in;
            r_exp    <= bus.exponent_in;
            r_idx    <= '0;
            r_err    <= 1'b0;
            r_issued <= 1'b0;
          end
        end
        CHECK: begin
          // 1 mod m, which is 0 for m==1; m==0 reports 0 with the error flag.
          r_acc <= (r_mod == KEY_WIDTH'(1) || r_mod == '0) ? '0 : KEY_WIDTH'(1);
          r_err <= (r_mod == '0);
        end
        REDUCE_IN, MUL, SQR: begin
          if (!r_issued) begin
            r_issued <= 1'b1;
          end else if (w_step_valid) begin
            r_issued <= 1'b0;
            case (r_state)
              REDUCE_IN: r_base <= w_step_result;
              // In constant-time mode a clear exponent bit makes this a dummy multiply.
              MUL: if (w_bits[0]) r_acc <= w_step_result;
              default: begin
                r_base <= w_step_result;
                r_idx  <= r_idx + 1'b1;
              end
            endcase
          end
        end
        DONE: r_res <= r_acc;
        default: ;
      endcase
    end
  end

  assign bus.value_out = (r_state == DONE) ? r_acc : r_res;
  assign bus.valid_out = (r_state == DONE);
  assign bus.error_out = (r_state == DONE) && r_err;
  assign bus.busy_out  = (r_state != IDLE) && (r_state != DONE);

endmodule

`default_nettype wire

// File: tb/tb_modexp_engine.sv
// ---------------------------------------------------------------------------
// tb_modexp_engine: directed self-checking bench for modexp_engine. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_modexp_engine;

  localparam int MW = 16;
  localparam int KW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  modexp_if #(.MSG_WIDTH(MW), .KEY_WIDTH(KW)) bus ();

  modexp_engine #(.MSG_WIDTH(MW), .KEY_WIDTH(KW)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  int vcount = 0;

  always @(posedge clk) if (bus.valid_out) vcount <= vcount + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [15:0] v, input logic [15:0] e, input logic [15:0] m);
    @(negedge clk);
    bus.value_in    = v;
    bus.exponent_in = e;
    bus.modulus_in  = m;
    bus.ready_in    = 1'b1;
    @(negedge clk);
    bus.ready_in    = 1'b0;
  endtask

  task automatic wait_valid(input string tag, output int cyc);
    cyc = 0;
    while (!bus.valid_out && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_timeout"}, bus.valid_out, 1);
  endtask

  task automatic run(input string tag, input logic [15:0] v, input logic [15:0] e,
                     input logic [15:0] m, input logic [15:0] exp_val,
                     input logic exp_err, output int cyc);
    start_op(v, e, m);
    check({tag, "_busy"}, bus.busy_out, 1);
    wait_valid(tag, cyc);
    check({tag, "_value"}, bus.value_out, exp_val);
    check({tag, "_error"}, bus.error_out, exp_err);
    check({tag, "_busy_done"}, bus.busy_out, 0);
    @(negedge clk);
    check({tag, "_pulse"}, bus.valid_out, 0);
  endtask

  initial begin
    int cyc, c1, c2, v0;
    rst             = 1'b1;
    bus.ready_in    = 1'b0;
    bus.value_in    = '0;
    bus.exponent_in = '0;
    bus.modulus_in  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_value", bus.value_out, 0);
    check("rst_busy", bus.busy_out, 0);
    check("rst_valid", bus.valid_out, 0);
    check("rst_error", bus.error_out, 0);

    run("p4e13m497", 16'd4, 16'd13, 16'd497, 16'd445, 1'b0, cyc);
    run("p500e2m497", 16'd500, 16'd2, 16'd497, 16'd9, 1'b0, cyc);
    run("e0m1000", 16'd5, 16'd0, 16'd1000, 16'd1, 1'b0, cyc);
    run("e0m1", 16'd5, 16'd0, 16'd1, 16'd0, 1'b0, cyc);
    run("m0", 16'd7, 16'd5, 16'd0, 16'd0, 1'b1, cyc);
    run("vmax_e1", 16'd65535, 16'd1, 16'd497, 16'd428, 1'b0, cyc);
    run("p2e16mmax", 16'd2, 16'd16, 16'd65535, 16'd1, 1'b0, cyc);
    run("p9e5m1", 16'd9, 16'd5, 16'd1, 16'd0, 1'b0, cyc);

    // Inputs change and ready_in pulses while busy; a DONE-cycle ready_in is ignored too.
    v0 = vcount;
    start_op(16'd2, 16'd10, 16'd1000);
    repeat (10) @(negedge clk);
    bus.value_in    = 16'd3;
    bus.exponent_in = 16'd7;
    bus.modulus_in  = 16'd11;
    bus.ready_in    = 1'b1;
    repeat (3) @(negedge clk);
    bus.ready_in    = 1'b0;
    wait_valid("midrun", cyc);
    check("midrun_value", bus.value_out, 24);
    check("midrun_error", bus.error_out, 0);
    bus.value_in    = 16'd4;
    bus.exponent_in = 16'd13;
    bus.modulus_in  = 16'd497;
    bus.ready_in    = 1'b1;
    @(negedge clk);
    bus.ready_in    = 1'b0;
    check("done_ready_ignored", bus.busy_out, 0);
    repeat (50) @(negedge clk);
    check("midrun_one_valid", vcount - v0, 1);
    check("midrun_held", bus.value_out, 24);

    // Reset in the middle of a computation.
    start_op(16'd4, 16'd13, 16'd497);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_value", bus.value_out, 0);
    check("abort_busy", bus.busy_out, 0);
    check("abort_valid", bus.valid_out, 0);
    check("abort_error", bus.error_out, 0);
    v0 = vcount;
    repeat (300) @(negedge clk);
    check("abort_no_valid", vcount - v0, 0);
    run("p3e3m7", 16'd3, 16'd3, 16'd7, 16'd6, 1'b0, cyc);

    run("p3e1m7", 16'd3, 16'd1, 16'd7, 16'd3, 1'b0, c1);
    run("p3emaxm7", 16'd3, 16'd65535, 16'd7, 16'd6, 1'b0, c2);
`ifdef MODEXP_CONST_TIME_EN
    check("const_time_latency", c2, c1);
`else
    check("early_term_faster", (c1 < c2) ? 1 : 0, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
